// File: rtl/nn_pkg.sv
// Shared types and defaults for the layer sequencer: FSM encoding,
// registered control bundle and the table/address size defaults.
package nn_pkg;

    localparam int AW_DEF = 8;
    localparam int MAX_LAYERS_DEF = 4;
    localparam int LW = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRIME0,
        PRIME1,
        ACC,
        WB,
        NEXT,
        FIN
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic ag_reset;
        logic ag_read;
        logic mac_clear;
        logic ram_wre;
    } ctl_t;

    // Control levels that hold while the FSM sits in state s.
    function automatic ctl_t ctl_of(state_t s);
        ctl_t c;
        c = '0;
        unique case (s)
            IDLE: ;
            LOAD: begin
                c.busy = 1'b1;
                c.ag_reset = 1'b1;
                c.mac_clear = 1'b1;
            end
            PRIME0, PRIME1: begin
                c.busy = 1'b1;
                c.ag_read = 1'b1;
                c.mac_clear = 1'b1;
            end
            ACC: c.busy = 1'b1;
            WB: begin
                c.busy = 1'b1;
                c.ram_wre = 1'b1;
            end
            NEXT: c.busy = 1'b1;
            FIN: c.done = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Sequencer <-> address generator / MAC / neuron-RAM control bundle.
// The sequencer is the master; the datapath side is the slave.
interface layer_sequencer_if
    import nn_pkg::*;
#(
    parameter int AW = AW_DEF
);

    logic ag_reset;
    logic ag_read;
    logic ag_finished;
    logic mac_clear;
    logic ram_wre;
    logic [AW-1:0] nk;
    logic [AW-1:0] weight_base;
    logic [AW-1:0] read_base;
    logic [AW-1:0] write_base;

    modport master (
        output ag_reset,
        output ag_read,
        output mac_clear,
        output ram_wre,
        output nk,
        output weight_base,
        output read_base,
        output write_base,
        input  ag_finished
    );

    modport slave (
        input  ag_reset,
        input  ag_read,
        input  mac_clear,
        input  ram_wre,
        input  nk,
        input  weight_base,
        input  read_base,
        input  write_base,
        output ag_finished
    );

endinterface

// File: rtl/layer_cfg_regs.sv
// Per-layer (nk, nn) table: synchronous write, combinational read,
// cleared on reset.
module layer_cfg_regs
    import nn_pkg::*;
#(
    parameter int MAX_LAYERS = MAX_LAYERS_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [LW-1:0] wr_idx,
    input  logic [AW-1:0] wr_nk,
    input  logic [AW-1:0] wr_nn,
    input  logic [LW-1:0] rd_idx,
    output logic [AW-1:0] rd_nk,
    output logic [AW-1:0] rd_nn
);

    logic [AW-1:0] nk_q [MAX_LAYERS];
    logic [AW-1:0] nn_q [MAX_LAYERS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                nk_q[i] <= '0;
                nn_q[i] <= '0;
            end
        end else if (we && int'(wr_idx) < MAX_LAYERS) begin
            nk_q[wr_idx] <= wr_nk;
            nn_q[wr_idx] <= wr_nn;
        end
    end

    always_comb begin
        rd_nk = '0;
        rd_nn = '0;
        if (int'(rd_idx) < MAX_LAYERS) begin
            rd_nk = nk_q[rd_idx];
            rd_nn = nn_q[rd_idx];
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Runs a multi-layer network: per neuron, launches the address
// generator, waits for Nk reads and writes the MAC result back.
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int MAX_LAYERS = MAX_LAYERS_DEF,
    parameter int AW = AW_DEF,
    parameter int IN_BASE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    num_layers,
    input  logic          cfg_we,
    input  logic [LW-1:0] cfg_layer,
    input  logic [AW-1:0] cfg_nk,
    input  logic [AW-1:0] cfg_nn,
    layer_sequencer_if.master bus,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] layer_idx,
    output logic [AW-1:0] neuron_idx
);

    localparam logic [AW-1:0] IN_B = AW'(IN_BASE);

    state_t state;
    state_t nxt;
    ctl_t ctl;

    logic [AW-1:0] nk_q;
    logic [AW-1:0] nn_q;
    logic [AW-1:0] wb_q;
    logic [AW-1:0] rb_q;
    logic [AW-1:0] wrb_q;
    logic [AW-1:0] nidx_q;
    logic [LW-1:0] lidx_q;
    logic [2:0] nl_q;

    logic [AW:0] nidx_inc;
    logic [2:0] lidx_inc;
    logic n_more;
    logic l_more;
    logic bad_nl;
    logic skip;

    logic cfg_wr;
    logic cfg_hit;
    logic [LW-1:0] ld_idx;
    logic [AW-1:0] rd_nk;
    logic [AW-1:0] rd_nn;
    logic [AW-1:0] ld_nk;
    logic [AW-1:0] ld_nn;

    assign nidx_inc = {1'b0, nidx_q} + {{AW{1'b0}}, 1'b1};
    assign lidx_inc = {1'b0, lidx_q} + 3'd1;
    assign n_more = nidx_inc < {1'b0, nn_q};
    assign l_more = lidx_inc < nl_q;
    assign bad_nl = (num_layers == 3'd0) || (int'(num_layers) > MAX_LAYERS);
    assign skip = (nk_q == '0) || (nn_q == '0);

    // Table is frozen during a run; an IDLE write forwards to a same-cycle start.
    assign cfg_wr = cfg_we && !ctl.busy;
    assign ld_idx = (state == IDLE) ? '0 : lidx_inc[LW-1:0];
    assign cfg_hit = cfg_we && (state == IDLE) && (cfg_layer == ld_idx);
    assign ld_nk = cfg_hit ? cfg_nk : rd_nk;
    assign ld_nn = cfg_hit ? cfg_nn : rd_nn;

    layer_cfg_regs #(
        .MAX_LAYERS(MAX_LAYERS),
        .AW(AW)
    ) u_cfg (
        .clk(clk),
        .reset(reset),
        .we(cfg_wr),
        .wr_idx(cfg_layer),
        .wr_nk(cfg_nk),
        .wr_nn(cfg_nn),
        .rd_idx(ld_idx),
        .rd_nk(rd_nk),
        .rd_nn(rd_nn)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (start) nxt = bad_nl ? FIN : LOAD;
            end
            LOAD: nxt = skip ? NEXT : PRIME0;
            PRIME0: nxt = PRIME1;
            PRIME1: nxt = ACC;
            ACC: begin
                if (bus.ag_finished) nxt = WB;
            end
            WB: nxt = n_more ? PRIME0 : NEXT;
            NEXT: nxt = l_more ? LOAD : FIN;
            FIN: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ctl <= '0;
            nk_q <= '0;
            nn_q <= '0;
            wb_q <= '0;
            rb_q <= '0;
            wrb_q <= '0;
            nidx_q <= '0;
            lidx_q <= '0;
            nl_q <= '0;
        end else begin
            state <= nxt;
            ctl <= ctl_of(nxt);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        lidx_q <= '0;
                        rb_q <= IN_B;
                        wb_q <= '0;
                        nl_q <= num_layers;
                        nk_q <= ld_nk;
                        nn_q <= ld_nn;
                        wrb_q <= IN_B + ld_nk;
                        nidx_q <= '0;
                    end
                end
                WB: begin
                    if (n_more) begin
                        nidx_q <= nidx_inc[AW-1:0];
                        wb_q <= wb_q + nk_q;
                    end
                end
                NEXT: begin
                    rb_q <= wrb_q;
                    if (!skip) wb_q <= wb_q + nk_q;
                    lidx_q <= lidx_inc[LW-1:0];
                    if (l_more) begin
                        nk_q <= ld_nk;
                        nn_q <= ld_nn;
                        wrb_q <= wrb_q + ld_nk;
                        nidx_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ag_reset = ctl.ag_reset | reset;
    assign bus.ag_read = ctl.ag_read;
    assign bus.mac_clear = ctl.mac_clear;
    assign bus.ram_wre = ctl.ram_wre;
    assign bus.nk = nk_q;
    assign bus.weight_base = wb_q;
    assign bus.read_base = rb_q;
    assign bus.write_base = wrb_q;

    assign busy = ctl.busy;
    assign done = ctl.done;
    assign layer_idx = lidx_q;
    assign neuron_idx = nidx_q;

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter MAX_LAYERS, default 4: depth of the per-layer config table.
REQ-002 Parameter AW, default 8: address and count width.
REQ-003 Parameter IN_BASE, default 0: neuron-RAM address of the network input vector.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to run the whole network.
REQ-007 num_layers  input  3  number of layers to run, sampled on an accepted start.
REQ-008 cfg_we, cfg_layer[1:0], cfg_nk[AW-1:0], cfg_nn[AW-1:0]  input  write port for the config table.
REQ-009 ag_finished  input  1  address generator has finished one neuron's Nk reads.
REQ-010 ag_reset, ag_read  output  1  address generator reset and read-launch controls.
REQ-011 nk, weight_base, read_base, write_base  output  AW  address generator configuration.
REQ-012 mac_clear  output  1  clears the MAC accumulator.
REQ-013 ram_wre  output  1  neuron-RAM write enable for the MAC result.
REQ-014 busy, done  output  1  busy = network run in progress; done = one-cycle completion pulse.
REQ-015 layer_idx[1:0], neuron_idx[AW-1:0]  output  current layer and current neuron position.

Function
REQ-016 FSM states: IDLE, LOAD, PRIME0, PRIME1, ACC, WB, NEXT, FIN.
REQ-017 IDLE: start=1 accepted -> LOAD; layer_idx=0; read_base=IN_BASE; weight_base=0; busy=1 from the next cycle.
REQ-018 LOAD: drive nk=cfg_nk[layer]; write_base=read_base+nk (mod 2^AW); neuron_idx=0; ag_reset=1, mac_clear=1 for 1 cycle -> PRIME0.
REQ-019 A layer with nk=0 or nn=0 is skipped: LOAD -> NEXT with no ag_read and no ram_wre.
REQ-020 PRIME0 and PRIME1: ag_read=1 and mac_clear=1 in both cycles, giving a 2-cycle launch pulse -> ACC.
REQ-021 ACC: wait for ag_finished=1 -> WB. ag_finished in PRIME0/PRIME1 is ignored. No timeout.
REQ-022 WB: ram_wre=1 for exactly 1 cycle, at address write_base+neuron_idx.
REQ-023 After WB:
- if neuron_idx+1 < nn: neuron_idx++, weight_base+=nk -> PRIME0;
- else -> NEXT.
REQ-024 NEXT:
- read_base := write_base; weight_base += nk when leaving a non-skipped layer; layer_idx++.
- if layer_idx+1 < num_layers -> LOAD, else -> FIN.
REQ-025 FIN: done=1 for 1 cycle, busy=0 -> IDLE.
REQ-026 num_layers=0 or num_layers>MAX_LAYERS on start: LOAD skipped; IDLE -> FIN -> IDLE with done one cycle after start.
REQ-027 start while busy is ignored. cfg_we while busy is ignored. A config write and a start in the same IDLE cycle: the config write takes effect first.
REQ-028 All address arithmetic is modulo 2^AW; wrap-around is silent.
REQ-029 Per-neuron latency from PRIME0 to WB = 2 + (cycles until ag_finished) + 1.

Reset
REQ-030 reset has priority over every other input, including mid-run.
REQ-031 On reset: state=IDLE; busy=done=ag_read=mac_clear=ram_wre=0; ag_reset=1 while reset is held.
REQ-032 On reset: all bases, nk, layer_idx and neuron_idx = 0.
REQ-033 The config table is cleared to 0 on reset.

Structure
REQ-034 The FSM state encoding, AW and MAX_LAYERS defaults live in a shared package, nn_pkg.
REQ-035 The config table is one sub-module, layer_cfg_regs: a synchronous-write, combinational-read register file.

Verification
REQ-036 Config layer0 nk=4 nn=2, num_layers=1, start; model ag_finished 4 cycles after PRIME1.
- Required: ram_wre at addresses 4 and 5; weight_base 0 then 4; one done pulse.
REQ-037 Two layers: L0 nk=3 nn=2, L1 nk=2 nn=1.
- Required: L1 read_base=3, write_base=5, weight_base=6; exactly 3 ram_wre pulses.
REQ-038 L0 nn=0, num_layers=1.
- Required: zero ag_read and zero ram_wre; done exactly 3 cycles after start.
REQ-039 Assert reset during ACC of neuron 1.
- Required: next cycle state=IDLE, busy=0, all bases 0; a subsequent start behaves exactly like REQ-036.
REQ-040 start during a run, and cfg_we while busy.
- Required: both ignored; layer output unchanged and a single done pulse.
REQ-041 nk=200, nn=100 with IN_BASE=0.
- Required: write_base=200, and write addresses wrap to 0..43 after 255.
